// File: rtl/cpu_run_pkg.sv
// ----------------------------------------------------------------------------
// cpu_run_pkg
//   Shared types and default constants for the CPU run controller.
//   - run_state_t : controller FSM states (IDLE, HOLD, RUN, DONE)
//   - DEF_*       : default parameter values used by cpu_run_ctrl and
//                   run_stall_det
//   - cnt_width() : width of a counter that must hold values 0..max_val
// ----------------------------------------------------------------------------
package cpu_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } run_state_t;

    localparam int unsigned DEF_PC_W        = 8;
    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_HOLD_CYCLES = 4;
    localparam int unsigned DEF_MAX_CYCLES  = 50;
    localparam int unsigned DEF_STALL_LIMIT = 3;

    // Bits needed to represent every value in 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : cpu_run_pkg

// File: rtl/run_stall_det.sv
// ----------------------------------------------------------------------------
// run_stall_det
//   Halt detector. Tracks how many consecutive enabled cycles the CPU program
//   counter has stayed unchanged and flags a halt once the current cycle would
//   be the STALL_LIMIT-th unchanged one.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous, active-high reset
//   clear   in   load prev_pc from pc and zero the stall count (run entry)
//   en      in   update tracking this cycle (CPU running)
//   pc      in   CPU program counter
//   halt_o  out  combinational: stall count at limit-1 and pc still unchanged
// ----------------------------------------------------------------------------
module run_stall_det
    import cpu_run_pkg::*;
#(
    parameter int unsigned PC_W        = DEF_PC_W,
    parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            en,
    input  logic [PC_W-1:0] pc,
    output logic            halt_o
);

    localparam int unsigned      SC_W       = cnt_width(STALL_LIMIT);
    localparam logic [SC_W-1:0]  STALL_LAST = SC_W'(STALL_LIMIT - 1);

    logic [PC_W-1:0] prev_pc_q;
    logic [SC_W-1:0] stall_cnt_q;
    logic [SC_W-1:0] stall_cnt_d;
    logic            pc_same;

    assign pc_same = (pc == prev_pc_q);

    // The stall count only reaches STALL_LIMIT-1 before the halt ends the run,
    // so the increment below never wraps.
    assign stall_cnt_d = pc_same ? stall_cnt_q + SC_W'(1) : '0;

    // Halt is reported in the cycle that completes the streak, so the
    // controller's registered done rises on the very next edge.
    assign halt_o = pc_same && (stall_cnt_q == STALL_LAST);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pc_q   <= '0;
            stall_cnt_q <= '0;
        end else if (clear) begin
            prev_pc_q   <= pc;
            stall_cnt_q <= '0;
        end else if (en) begin
            prev_pc_q   <= pc;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule : run_stall_det

// File: rtl/cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_run_ctrl
//   Run controller for the 16-bit RISC CPU. Holds the CPU in reset for
//   HOLD_CYCLES cycles after start, then enables it with run. The run ends on
//   abort, on halt (PC unchanged for STALL_LIMIT cycles) or on timeout
//   (MAX_CYCLES run cycles), with priority abort > halt > timeout. Results are
//   held in DONE until the next start.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset (highest priority)
//   start        in   pulse: begin a run from IDLE or DONE
//   abort        in   pulse: end a run in RUN without pass/fail flags
//   pc           in   CPU program counter, sampled each cycle
//   cpu_rst      out  reset to the CPU (high in IDLE and HOLD)
//   run          out  clock-enable to the CPU (high in RUN)
//   done         out  high while in DONE
//   halted       out  last run ended by halt detection
//   timeout      out  last run ended by the cycle budget
//   cycle_count  out  RUN cycles elapsed in the current/last run
// All outputs are registered.
// ----------------------------------------------------------------------------
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int unsigned PC_W        = DEF_PC_W,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_rst,
    output logic             run,
    output logic             done,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks. MAX_CYCLES below 2**CNT_W is what
    // keeps cycle_count from ever wrapping.
    // ------------------------------------------------------------------
    if ((PC_W < 1) || (CNT_W < 1) || (HOLD_CYCLES < 1) || (MAX_CYCLES < 2) ||
        (STALL_LIMIT < 1) ||
        ((CNT_W < 32) && (MAX_CYCLES >= (32'd1 << CNT_W)))) begin : g_bad_params
        $error("cpu_run_ctrl: illegal parameter combination");
    end

    localparam int unsigned      HC_W       = cnt_width(HOLD_CYCLES);
    localparam logic [HC_W-1:0]  HOLD_LAST  = HC_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);

    run_state_t       state_q;
    logic [HC_W-1:0]  hold_cnt_q;
    logic [HC_W-1:0]  hold_cnt_d;
    logic [CNT_W-1:0] cycle_count_q;
    logic [CNT_W-1:0] cycle_count_d;
    logic             cpu_rst_q;
    logic             run_q;
    logic             done_q;
    logic             halted_q;
    logic             timeout_q;

    logic             hold_exit;
    logic             timeout_hit;
    logic             halt;
    logic             stall_en;

    // NOTE: every signal driven here is assigned on every path through the
    // block; a missing assignment would infer a latch.
    always_comb begin
        hold_cnt_d    = hold_cnt_q + HC_W'(1);
        cycle_count_d = cycle_count_q + CNT_W'(1);
        hold_exit     = (state_q == HOLD) && (hold_cnt_q == HOLD_LAST);
        timeout_hit   = (cycle_count_q == TIMEOUT_AT);
        stall_en      = (state_q == RUN);
    end

    // prev_pc is captured on the HOLD exit edge so the first RUN cycle
    // compares against the PC the CPU presented while leaving reset.
    run_stall_det #(
        .PC_W        (PC_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall_det (
        .clk    (clk),
        .reset  (reset),
        .clear  (hold_exit),
        .en     (stall_en),
        .pc     (pc),
        .halt_o (halt)
    );

    // ------------------------------------------------------------------
    // Controller FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            cycle_count_q <= '0;
            cpu_rst_q     <= 1'b1;
            run_q         <= 1'b0;
            done_q        <= 1'b0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= HOLD;
                        hold_cnt_q <= '0;
                        halted_q   <= 1'b0;
                        timeout_q  <= 1'b0;
                    end
                end

                HOLD: begin
                    hold_cnt_q <= hold_cnt_d;
                    if (hold_exit) begin
                        state_q       <= RUN;
                        cycle_count_q <= '0;
                        cpu_rst_q     <= 1'b0;
                        run_q         <= 1'b1;
                    end
                end

                RUN: begin
                    // The terminating cycle is itself a run cycle, so the
                    // count advances on the exit edge as well.
                    cycle_count_q <= cycle_count_d;
                    if (abort || halt || timeout_hit) begin
                        state_q   <= DONE;
                        run_q     <= 1'b0;
                        done_q    <= 1'b1;
                        halted_q  <= !abort && halt;
                        timeout_q <= !abort && !halt && timeout_hit;
                    end
                end

                DONE: begin
                    if (start) begin
                        state_q    <= HOLD;
                        hold_cnt_q <= '0;
                        cpu_rst_q  <= 1'b1;
                        done_q     <= 1'b0;
                        halted_q   <= 1'b0;
                        timeout_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    cpu_rst_q <= 1'b1;
                    run_q     <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rst     = cpu_rst_q;
    assign run         = run_q;
    assign done        = done_q;
    assign halted      = halted_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;

endmodule : cpu_run_ctrl
